// File: rtl/pong_pkg.sv
// Shared types and default playfield constants for the Pong ball engine.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_WAIT = 2'd1,
    MOVING     = 2'd2,
    SCORED     = 2'd3
  } state_e;

  // 640x480 playfield with a margin at each edge
  localparam int unsigned FIELD_W     = 640;
  localparam int unsigned FIELD_H     = 480;
  localparam int unsigned DEF_X_MIN   = 10;
  localparam int unsigned DEF_X_MAX   = 625;
  localparam int unsigned DEF_Y_MIN   = 10;
  localparam int unsigned DEF_Y_MAX   = 470;
  localparam int unsigned DEF_X_START = 300;
  localparam int unsigned DEF_Y_START = 250;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/axis_stepper.sv
// One-axis +/-speed step with clamping to [LIM_MIN, LIM_MAX] and limit flags.
module axis_stepper
  import pong_pkg::*;
#(
  parameter int unsigned POS_W   = 10,
  parameter int unsigned SPD_W   = 3,
  parameter int unsigned LIM_MIN = 10,
  parameter int unsigned LIM_MAX = 470
) (
  input  logic [POS_W-1:0] pos_i,
  input  logic             dir_i,
  input  logic [SPD_W-1:0] speed_i,
  output logic [POS_W-1:0] pos_c_o,
  output logic             lo_c_o,
  output logic             hi_c_o
);

  localparam int unsigned EXT_W = POS_W + 1;

  logic [EXT_W-1:0] pos_ext;
  logic [EXT_W-1:0] spd_ext;
  logic [EXT_W-1:0] sum;

  // Extra MSB catches a borrow when stepping below zero
  always_comb begin
    pos_ext = EXT_W'(pos_i);
    spd_ext = EXT_W'(speed_i);
    sum     = (dir_i == DIR_POS) ? (pos_ext + spd_ext) : (pos_ext - spd_ext);
    lo_c_o  = (dir_i == DIR_NEG) && (sum[POS_W] || (sum <= EXT_W'(LIM_MIN)));
    hi_c_o  = (dir_i == DIR_POS) && (sum >= EXT_W'(LIM_MAX));
    pos_c_o = sum[POS_W-1:0];
    if (lo_c_o) begin
      pos_c_o = POS_W'(LIM_MIN);
    end else if (hi_c_o) begin
      pos_c_o = POS_W'(LIM_MAX);
    end
  end

endmodule

// File: rtl/ball_motion_unit.sv
// Pong ball engine: serve sequencing, per-tick motion, wall bounce,
// paddle deflection with speed ramp, and miss detection with score pulses.
module ball_motion_unit
  import pong_pkg::*;
#(
  parameter int unsigned POS_W       = 10,
  parameter int unsigned X_MIN       = DEF_X_MIN,
  parameter int unsigned X_MAX       = DEF_X_MAX,
  parameter int unsigned Y_MIN       = DEF_Y_MIN,
  parameter int unsigned Y_MAX       = DEF_Y_MAX,
  parameter int unsigned X_START     = DEF_X_START,
  parameter int unsigned Y_START     = DEF_Y_START,
  parameter int unsigned SPD_W       = 3,
  parameter int unsigned SPEED_INIT  = 1,
  parameter int unsigned SPEED_MAX   = 5,
  parameter int unsigned HITS_PER_UP = 4,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             serve,
  input  logic             hit_left,
  input  logic             hit_right,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             x_dir,
  output logic             y_dir,
  output logic [SPD_W-1:0] speed,
  output logic             active,
  output logic             score_left,
  output logic             score_right
);

  if (SPEED_MAX >= (1 << SPD_W)) begin : g_bad_spd_w
    $error("SPEED_MAX does not fit in SPD_W bits");
  end
  if ((SPEED_MAX >= Y_MIN) || (SPEED_MAX >= X_MIN)) begin : g_bad_margin
    $error("SPEED_MAX must be below X_MIN and Y_MIN");
  end
  if ((X_MAX + SPEED_MAX) >= (1 << POS_W)) begin : g_bad_pos_w
    $error("X_MAX+SPEED_MAX does not fit in POS_W bits");
  end

  state_e           state_q, state_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic             xdir_q, xdir_d, ydir_q, ydir_d;
  logic [SPD_W-1:0] speed_q, speed_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, dly_q, dly_d;
  logic             active_q, active_d;
  logic             score_l_q, score_l_d, score_r_q, score_r_d;

  logic [POS_W-1:0] x_step, y_step;
  logic             x_lo, x_hi, y_lo, y_hi;
  logic             hit_acc, miss, serve_ok;

  axis_stepper #(.POS_W(POS_W), .SPD_W(SPD_W), .LIM_MIN(X_MIN), .LIM_MAX(X_MAX)) u_x_step (
    .pos_i(x_q), .dir_i(xdir_q), .speed_i(speed_q),
    .pos_c_o(x_step), .lo_c_o(x_lo), .hi_c_o(x_hi)
  );

  axis_stepper #(.POS_W(POS_W), .SPD_W(SPD_W), .LIM_MIN(Y_MIN), .LIM_MAX(Y_MAX)) u_y_step (
    .pos_i(y_q), .dir_i(ydir_q), .speed_i(speed_q),
    .pos_c_o(y_step), .lo_c_o(y_lo), .hi_c_o(y_hi)
  );

  // Only a hit opposing the current travel direction deflects the ball
  assign hit_acc  = (state_q == MOVING) &&
                    ((hit_left && (xdir_q == DIR_NEG)) || (hit_right && (xdir_q == DIR_POS)));
  assign miss     = tick && (x_lo || x_hi) && !hit_acc;
  assign serve_ok = serve && ((state_q == IDLE) || (state_q == SCORED));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (serve) state_d = SERVE_WAIT;
      SERVE_WAIT: if (tick && (dly_q == '0)) state_d = MOVING;
      MOVING:     if (miss) state_d = SCORED;
      SCORED:     if (serve) state_d = SERVE_WAIT;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    xdir_d    = xdir_q;
    ydir_d    = ydir_q;
    speed_d   = speed_q;
    hit_cnt_d = hit_cnt_q;
    dly_d     = dly_q;
    score_l_d = 1'b0;
    score_r_d = 1'b0;
    active_d  = (state_d == MOVING);

    if (serve_ok) begin
      x_d       = POS_W'(X_START);
      y_d       = POS_W'(Y_START);
      speed_d   = SPD_W'(SPEED_INIT);
      hit_cnt_d = '0;
      dly_d     = CNT_W'(SERVE_DELAY);
    end

    if ((state_q == SERVE_WAIT) && tick && (dly_q != '0)) begin
      dly_d = dly_q - CNT_W'(1);
    end

    if ((state_q == MOVING) && tick) begin
      x_d = x_step;
      y_d = y_step;
      if (y_lo) ydir_d = DIR_POS;
      if (y_hi) ydir_d = DIR_NEG;
      // Next serve heads toward the side that conceded
      if (miss) begin
        score_l_d = x_hi;
        score_r_d = x_lo;
        xdir_d    = x_hi ? DIR_POS : DIR_NEG;
      end
    end

    if (hit_acc) begin
      xdir_d = ~xdir_q;
      if (hit_cnt_q == CNT_W'(HITS_PER_UP - 1)) begin
        hit_cnt_d = '0;
        if (speed_q < SPD_W'(SPEED_MAX)) speed_d = speed_q + SPD_W'(1);
      end else begin
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= POS_W'(X_START);
      y_q       <= POS_W'(Y_START);
      xdir_q    <= DIR_POS;
      ydir_q    <= DIR_POS;
      speed_q   <= SPD_W'(SPEED_INIT);
      hit_cnt_q <= '0;
      dly_q     <= '0;
      active_q  <= 1'b0;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      xdir_q    <= xdir_d;
      ydir_q    <= ydir_d;
      speed_q   <= speed_d;
      hit_cnt_q <= hit_cnt_d;
      dly_q     <= dly_d;
      active_q  <= active_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign x_dir       = xdir_q;
  assign y_dir       = ydir_q;
  assign speed       = speed_q;
  assign active      = active_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;

endmodule
